writeback_queue: RTL and testbench

Write-side companion of the register file. Collects results from two producers: the single-cycle ALU path (port A) and the long-latency load/mul-div path (port B). Buffers them in an in-order FIFO and drains one entry per cycle into the register file's single write port (regWrite/rd/writeData). Also gives the decode stage combinational forwarding of still-pending results so reads never return stale data.

---
 rtl/writeback_queue.sv | 138 +++++++++++++
 tb/tb_writeback_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// writeback_queue: in-order result buffer between two producers and the
// register file's single write port. Port A (single-cycle ALU) and port B
// (long-latency load/mul-div) enqueue results, and one entry drains per
// cycle. Decode can read still-pending results combinationally through
// two forwarding ports.
module writeback_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64,
   parameter int AW    = 5
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       a_valid,
   input  logic [AW-1:0]              a_rd,
   input  logic [XLEN-1:0]            a_data,
   output logic                       a_ready,
   input  logic                       b_valid,
   input  logic [AW-1:0]              b_rd,
   input  logic [XLEN-1:0]            b_data,
   output logic                       b_ready,
   output logic                       regWrite,
   output logic [AW-1:0]              rd,
   output logic [XLEN-1:0]            writeData,
   input  logic [AW-1:0]              rs1,
   input  logic [AW-1:0]              rs2,
   output logic                       fwd1_hit,
   output logic [XLEN-1:0]            fwd1_data,
   output logic                       fwd2_hit,
   output logic [XLEN-1:0]            fwd2_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] DEPTH_M2 = CW'(DEPTH - 2);

   logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0]   count_reg, count_next;

   // Storage has no reset: occupancy is defined purely by the pointers/count.
   logic [AW-1:0]   rd_mem   [DEPTH];
   logic [XLEN-1:0] data_mem [DEPTH];

   logic            a_enq, b_enq, pop;
   logic [PW-1:0]   b_slot;

   // Forwarding helpers, indexed by age (0 = head/oldest).
   logic [PW-1:0]   idx_age [DEPTH];
   logic            m1_age  [DEPTH];
   logic            m2_age  [DEPTH];

   // Readiness looks only at the current count; a same-cycle pop never
   // frees a slot early. When A is also valid, B needs room for two so
   // that A keeps priority on the last free slot.
   assign a_ready = ~reset & (count_reg < DEPTH_C);
   assign b_ready = ~reset & (a_valid ? (count_reg <= DEPTH_M2)
                                      : (count_reg <  DEPTH_C));

   // Writes to x0 complete the handshake but are dropped here.
   assign a_enq  = a_valid & a_ready & (a_rd != '0);
   assign b_enq  = b_valid & b_ready & (b_rd != '0);
   assign b_slot = a_enq ? wr_ptr_reg + PW'(1) : wr_ptr_reg;

   assign pop      = (count_reg != '0);
   assign regWrite = pop;
   assign rd        = pop ? rd_mem[rd_ptr_reg]   : '0;
   assign writeData = pop ? data_mem[rd_ptr_reg] : '0;

   assign count = count_reg;
   assign full  = (count_reg == DEPTH_C);
   assign empty = (count_reg == '0);

   // Next-state arithmetic for pointers and occupancy.
   always_comb begin
      wr_ptr_next = wr_ptr_reg + PW'(a_enq) + PW'(b_enq);
      rd_ptr_next = rd_ptr_reg + PW'(pop);
      count_next  = count_reg + CW'(a_enq) + CW'(b_enq) - CW'(pop);
   end

   // Pointer and count registers; reset discards every pending entry at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Entry storage: A lands at the tail, B right behind it (A is older).
   always_ff @(posedge clk) begin
      if (a_enq) begin
         rd_mem[wr_ptr_reg]   <= a_rd;
         data_mem[wr_ptr_reg] <= a_data;
      end
      if (b_enq) begin
         rd_mem[b_slot]   <= b_rd;
         data_mem[b_slot] <= b_data;
      end
   end

   // Per-age match flags: an entry matches if it is live and holds rsN.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
         assign idx_age[gi] = rd_ptr_reg + PW'(gi);
         assign m1_age[gi]  = (CW'(gi) < count_reg) && (rs1 != '0) &&
                              (rd_mem[idx_age[gi]] == rs1);
         assign m2_age[gi]  = (CW'(gi) < count_reg) && (rs2 != '0) &&
                              (rd_mem[idx_age[gi]] == rs2);
      end
   endgenerate

   // Youngest match wins: scan oldest to youngest, later hits overwrite.
   always_comb begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (m1_age[k]) begin
            fwd1_hit  = 1'b1;
            fwd1_data = data_mem[idx_age[k]];
         end
         if (m2_age[k]) begin
            fwd2_hit  = 1'b1;
            fwd2_data = data_mem[idx_age[k]];
         end
      end
   end

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a write-order scoreboard.
module tb_writeback_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 64;
   localparam int AW    = 5;

   logic            clk;
   logic            reset;
   logic            a_valid, b_valid, a_ready, b_ready;
   logic [AW-1:0]   a_rd, b_rd, rd, rs1, rs2;
   logic [XLEN-1:0] a_data, b_data, writeData, fwd1_data, fwd2_data;
   logic            regWrite, fwd1_hit, fwd2_hit, full, empty;
   logic [$clog2(DEPTH):0] count;

   int total = 0;
   int bad   = 0;
   logic [AW+XLEN-1:0] sb [$];

   writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
      .regWrite(regWrite), .rd(rd), .writeData(writeData),
      .rs1(rs1), .rs2(rs2),
      .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
      .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
      .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transfer cycle: drive, check readiness/count before the edge,
   // record accepted non-x0 results (A before B), then take the edge.
   task automatic drive(input string tag,
                        input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                        input logic bv, input logic [AW-1:0] brd, input logic [XLEN-1:0] bd,
                        input int ecnt, input logic ea, input logic eb);
      a_valid = av; a_rd = ard; a_data = ad;
      b_valid = bv; b_rd = brd; b_data = bd;
      #1;
      chk({tag, "_count"},   64'(count),   64'(ecnt));
      chk({tag, "_a_ready"}, 64'(a_ready), 64'(ea));
      chk({tag, "_b_ready"}, 64'(b_ready), 64'(eb));
      $display("drive %s: A v=%0b rd=%0d d=%0h  B v=%0b rd=%0d d=%0h", tag, av, ard, ad, bv, brd, bd);
      if (av && ea && ard != '0) sb.push_back({ard, ad});
      if (bv && eb && brd != '0) sb.push_back({brd, bd});
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   // Scoreboard: each cycle with regWrite high, the head must match the
   // oldest expected result.
   always @(negedge clk) begin
      logic [AW+XLEN-1:0] ent;
      if (reset === 1'b0 && regWrite === 1'b1) begin
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_write observed rd=%0d data=%0h expected no write", rd, writeData);
         end
         if (sb.size() != 0) begin
            ent = sb.pop_front();
            $display("write rd=%0d data=%0h (expected rd=%0d data=%0h)", rd, writeData, ent[AW+XLEN-1:XLEN], ent[XLEN-1:0]);
            chk("wr_rd",   64'(rd),   64'(ent[AW+XLEN-1:XLEN]));
            chk("wr_data", writeData, ent[XLEN-1:0]);
         end
      end
   end

   initial begin
      reset = 1'b0;
      a_valid = 1'b0; a_rd = '0; a_data = '0;
      b_valid = 1'b0; b_rd = '0; b_data = '0;
      rs1 = '0; rs2 = '0;
      #2 reset = 1'b1;
      #1;
      chk("rst_regWrite", 64'(regWrite), 64'd0);
      chk("rst_count",    64'(count),    64'd0);
      chk("rst_empty",    64'(empty),    64'd1);
      chk("rst_full",     64'(full),     64'd0);
      chk("rst_a_ready",  64'(a_ready),  64'd0);
      chk("rst_b_ready",  64'(b_ready),  64'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("rel_regWrite", 64'(regWrite), 64'd0);
      chk("rel_count",    64'(count),    64'd0);
      chk("rel_empty",    64'(empty),    64'd1);
      chk("rel_fwd1_hit", 64'(fwd1_hit), 64'd0);
      tick();

      // 1: single A result, one-cycle latency to the write port
      rs1 = 5'd5;
      drive("t1", 1, 5'd5, 64'h11, 0, 5'd0, 64'h0, 0, 1, 1);
      chk("t1_regWrite",  64'(regWrite), 64'd1);
      chk("t1_rd",        64'(rd),       64'd5);
      chk("t1_wdata",     writeData,     64'h11);
      chk("t1_fwd1_hit",  64'(fwd1_hit), 64'd1);
      chk("t1_fwd1_data", fwd1_data,     64'h11);
      chk("t1_count",     64'(count),    64'd1);
      tick();
      chk("t1_drained",   64'(regWrite), 64'd0);
      chk("t1_empty",     64'(empty),    64'd1);
      chk("t1_fwd1_gone", 64'(fwd1_hit), 64'd0);

      // 2: A and B to the same register in one cycle; B is youngest
      rs1 = 5'd3;
      drive("t2", 1, 5'd3, 64'hAA, 1, 5'd3, 64'hBB, 0, 1, 1);
      chk("t2_count",     64'(count), 64'd2);
      chk("t2_fwd1_data", fwd1_data,  64'hBB);
      chk("t2_head_data", writeData,  64'hAA);
      tick();
      chk("t2_count1",    64'(count), 64'd1);
      chk("t2_fwd1_last", fwd1_data,  64'hBB);
      tick();
      chk("t2_count0",    64'(count), 64'd0);

      // 3: sustained A+B while draining; B stalls at count 3, pointers wrap
      drive("t3a", 1, 5'd1,  64'h101, 1, 5'd2, 64'h102, 0, 1, 1);
      drive("t3b", 1, 5'd4,  64'h104, 1, 5'd6, 64'h106, 2, 1, 1);
      drive("t3c", 1, 5'd8,  64'h108, 1, 5'd9, 64'h109, 3, 1, 0);
      drive("t3d", 1, 5'd10, 64'h10A, 1, 5'd9, 64'h109, 3, 1, 0);
      drive("t3e", 0, 5'd0,  64'h0,   1, 5'd9, 64'h109, 3, 1, 1);
      chk("t3_count3", 64'(count), 64'd3);
      chk("t3_full",   64'(full),  64'd0);
      tick();
      chk("t3_count2", 64'(count), 64'd2);
      tick();
      chk("t3_count1", 64'(count), 64'd1);
      tick();
      chk("t3_count0", 64'(count), 64'd0);

      // 4: x0 writes handshake but never enqueue; B alone lands at the tail
      rs1 = 5'd0;
      drive("t4a", 1, 5'd0, 64'hFF, 0, 5'd0, 64'h0, 0, 1, 1);
      chk("t4_count",    64'(count),    64'd0);
      chk("t4_regWrite", 64'(regWrite), 64'd0);
      chk("t4_fwd1_hit", 64'(fwd1_hit), 64'd0);
      drive("t4b", 1, 5'd0, 64'hFF, 1, 5'd12, 64'hC12, 0, 1, 1);
      chk("t4b_count", 64'(count), 64'd1);
      chk("t4b_rd",    64'(rd),    64'd12);
      chk("t4b_data",  writeData,  64'hC12);
      tick();
      chk("t4b_count0", 64'(count), 64'd0);

      // 6: three pending rd=7 values; forwarding follows the youngest
      rs2 = 5'd7;
      drive("t6a", 1, 5'd7, 64'h1, 1, 5'd7, 64'h2, 0, 1, 1);
      chk("t6_hit_a",  64'(fwd2_hit), 64'd1);
      chk("t6_data_a", fwd2_data,     64'h2);
      drive("t6b", 1, 5'd7, 64'h3, 0, 5'd0, 64'h0, 2, 1, 1);
      chk("t6_data_b", fwd2_data,  64'h3);
      chk("t6_count",  64'(count), 64'd2);
      tick();
      chk("t6_data_c", fwd2_data,     64'h3);
      chk("t6_hit_c",  64'(fwd2_hit), 64'd1);
      tick();
      chk("t6_hit_gone",  64'(fwd2_hit), 64'd0);
      chk("t6_data_gone", fwd2_data,     64'h0);

      // 5: asynchronous reset mid-drain discards everything
      drive("t5a", 1, 5'd11, 64'h511, 1, 5'd13, 64'h513, 0, 1, 1);
      drive("t5b", 1, 5'd14, 64'h514, 1, 5'd15, 64'h515, 2, 1, 1);
      rs1 = 5'd14; rs2 = 5'd15;
      #1;
      chk("t5_count_pre", 64'(count),    64'd3);
      chk("t5_fwd1_pre",  fwd1_data,     64'h514);
      chk("t5_fwd2_pre",  64'(fwd2_hit), 64'd1);
      reset = 1'b1;
      #1;
      chk("t5_regWrite", 64'(regWrite), 64'd0);
      chk("t5_count",    64'(count),    64'd0);
      chk("t5_empty",    64'(empty),    64'd1);
      chk("t5_fwd1_hit", 64'(fwd1_hit), 64'd0);
      chk("t5_fwd2_hit", 64'(fwd2_hit), 64'd0);
      sb.delete();
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_post_regWrite", 64'(regWrite), 64'd0);
         chk("t5_post_count",    64'(count),    64'd0);
      end

      chk("sb_leftover", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
